// File: rtl/sequencer_pkg.sv
// Shared types and constants for the CPU control sequencer.
// State codes 0..5 match the original encoding; SHALT/SERR extend it.
package sequencer_pkg;

    localparam int unsigned OPCODE_WIDTH = 8;
    localparam int unsigned IP_WIDTH     = 8;

    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        SRST   = 3'd0,
        SREAD  = 3'd1,
        SLOAD1 = 3'd2,
        SLOAD2 = 3'd3,
        SCALC  = 3'd4,
        SWRITE = 3'd5,
        SHALT  = 3'd6,
        SERR   = 3'd7
    } SequencerState;

    // States in which the sequencer waits on the RAM handshake.
    function automatic logic is_wait_state(input SequencerState s);
        return (s == SLOAD1) || (s == SLOAD2) || (s == SWRITE);
    endfunction

endpackage

// File: rtl/sequencer_rise_detect.sv
// Registered 1-bit rising-edge detector used for the single-step request.
module rise_detect (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    always_comb begin
        rise = d & ~d_q;
    end

endmodule

// File: rtl/sequencer.sv
// Control FSM stepping the CPU core through read/load/calc/write per program
// line, with RAM stall handling, halt/wrap detection and a sticky timeout error.
module sequencer
    import sequencer_pkg::*;
#(
    parameter int unsigned               TIMEOUT_CYCLES = 16,
    parameter logic [OPCODE_WIDTH-1:0]   HALT_OPCODE    = HALT_OPCODE_DEFAULT,
    parameter int unsigned               COUNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    run,
    input  logic                    step,
    input  logic                    ram_busy,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [IP_WIDTH-1:0]     ip,
    output SequencerState           q,
    output logic                    err,
    output logic                    halted,
    output logic [COUNT_WIDTH-1:0]  instr_count
);

    // Wide enough to hold TIMEOUT_CYCLES itself: that many busy cycles are legal.
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    SequencerState          state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   err_q, err_d;
    logic                   halted_q, halted_d;
    logic                   step_rise;
    logic                   go;
    logic                   timed_out;

    rise_detect u_step_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (step),
        .rise (step_rise)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= SRST;
            wait_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        go        = run | step_rise;
        timed_out = ram_busy && (wait_q == WAIT_W'(TIMEOUT_CYCLES));
        state_d   = state_q;
        count_d   = count_q;

        case (state_q)
            SRST:   if (go) state_d = SREAD;
            SREAD:  state_d = SLOAD1;
            SLOAD1: begin
                if (timed_out)     state_d = SERR;
                else if (!ram_busy) state_d = SLOAD2;
            end
            SLOAD2: begin
                if (timed_out)     state_d = SERR;
                else if (!ram_busy) state_d = SCALC;
            end
            SCALC:  state_d = (opcode == HALT_OPCODE) ? SHALT : SWRITE;
            SWRITE: begin
                if (timed_out) begin
                    state_d = SERR;
                end else if (!ram_busy) begin
                    count_d = count_q + 1'b1;
                    // ip already advanced in SCALC, so zero means it wrapped.
                    state_d = (ip == '0) ? SHALT : SRST;
                end
            end
            default: state_d = state_q;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (is_wait_state(state_q) && ram_busy) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_comb begin
        err_d       = (state_d == SERR);
        halted_d    = (state_d == SHALT);
        q           = state_q;
        err         = err_q;
        halted      = halted_q;
        instr_count = count_q;
    end

endmodule
